// File: rtl/multi_crop_stream.sv
// Extracts NUM_CROPS fixed-size windows from a raster pixel stream, tagging each output with its crop index.
// Latency: one cycle from an accepted input pixel to its first output beat; overlapping crops emit back-to-back.
// Backpressure: output stalls hold the payload; input is accepted only when the last pending output beat retires.
//
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   ap_start/done/ready/idle  frame-level control: start in IDLE, one-cycle done/ready pulse at frame end
//   img_input_T*              raster pixel stream (IN_ROWS x IN_COLS pixels per frame)
//   crop_Y1_T*, crop_X1_T*    top-left corners, consumed as pairs, one pair per crop slot
//   crop_output_T*            cropped pixels; TUSER = crop index, TLAST = last pixel of that crop
module multi_crop_stream #(
    parameter int PIXEL_BIT_WIDTH  = 16,
    parameter int IN_ROWS          = 100,
    parameter int IN_COLS          = 160,
    parameter int OUT_ROWS         = 48,
    parameter int OUT_COLS         = 48,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10,
    parameter int NUM_CROPS        = 2,
    localparam int UW = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        ap_start,
    output logic                        ap_done,
    output logic                        ap_ready,
    output logic                        ap_idle,
    input  logic [PIXEL_BIT_WIDTH-1:0]  img_input_TDATA,
    input  logic                        img_input_TVALID,
    output logic                        img_input_TREADY,
    input  logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
    input  logic                        crop_Y1_TVALID,
    output logic                        crop_Y1_TREADY,
    input  logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
    input  logic                        crop_X1_TVALID,
    output logic                        crop_X1_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0]  crop_output_TDATA,
    output logic                        crop_output_TVALID,
    input  logic                        crop_output_TREADY,
    output logic [UW-1:0]               crop_output_TUSER,
    output logic                        crop_output_TLAST
);

    localparam int RW  = IMG_ROW_BITWIDTH;
    localparam int CW  = IMG_COL_BITWIDTH;
    localparam int RW1 = RW + 1;
    localparam int CW1 = CW + 1;

    localparam logic [RW-1:0]  Y1_MAX    = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [CW-1:0]  X1_MAX    = CW'(IN_COLS - OUT_COLS);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0]  COL_LAST  = CW'(IN_COLS - 1);
    localparam logic [RW1-1:0] CROP_H    = RW1'(OUT_ROWS);
    localparam logic [CW1-1:0] CROP_W    = CW1'(OUT_COLS);
    localparam logic [RW1-1:0] CROP_H_M1 = RW1'(OUT_ROWS - 1);
    localparam logic [CW1-1:0] CROP_W_M1 = CW1'(OUT_COLS - 1);
    localparam logic [UW-1:0]  SLOT_LAST = UW'(NUM_CROPS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]                 state;
    logic [2:0]                 state_nxt;

    // crop corners, already clamped so every window lies inside the frame
    logic [RW-1:0]              y1 [NUM_CROPS];
    logic [CW-1:0]              x1 [NUM_CROPS];
    logic [UW-1:0]              slot;

    // raster position of the next pixel to be accepted
    logic [RW-1:0]              row;
    logic [CW-1:0]              col;
    logic                       last_seen;

    // pixel being emitted, its position and the crops still owed a copy
    logic [PIXEL_BIT_WIDTH-1:0] pix_q;
    logic [RW-1:0]              row_q;
    logic [CW-1:0]              col_q;
    logic [NUM_CROPS-1:0]       mask_q;

    logic [NUM_CROPS-1:0]       hit;
    logic [NUM_CROPS-1:0]       sel_oh;
    logic [NUM_CROPS-1:0]       mask_rem;
    logic [UW-1:0]              sel;
    logic                       mask_single;
    logic                       tlast;

    logic [RW-1:0]              y1_clamped;
    logic [CW-1:0]              x1_clamped;

    logic                       cap_fire;
    logic                       in_rdy;
    logic                       in_fire;
    logic                       out_vld;
    logic                       out_fire;
    logic                       pix_last;

    assign y1_clamped = (crop_Y1_TDATA > Y1_MAX) ? Y1_MAX : crop_Y1_TDATA;
    assign x1_clamped = (crop_X1_TDATA > X1_MAX) ? X1_MAX : crop_X1_TDATA;

    // A corner pair is taken only when both halves are present together.
    assign cap_fire = (state == S_LOAD) && crop_Y1_TVALID && crop_X1_TVALID;

    assign pix_last = (row == ROW_LAST) && (col == COL_LAST);

    // Lowest pending crop is served first; the rest stay in mask_rem.
    assign sel_oh      = mask_q & (~mask_q + NUM_CROPS'(1));
    assign mask_rem    = mask_q & ~sel_oh;
    assign mask_single = (mask_q != '0) && (mask_rem == '0);

    assign out_vld  = (state == S_EMIT);
    assign out_fire = out_vld && crop_output_TREADY;

    // During EMIT a new pixel may only enter when the final pending beat is
    // leaving this cycle, so the held pixel is never overwritten early.
    assign in_rdy  = (state == S_STREAM) ||
                     ((state == S_EMIT) && mask_single && crop_output_TREADY);
    assign in_fire = in_rdy && img_input_TVALID;

    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_CROPS; k++) begin
            hit[k] = ({1'b0, row} >= {1'b0, y1[k]}) &&
                     ({1'b0, row} <  ({1'b0, y1[k]} + CROP_H)) &&
                     ({1'b0, col} >= {1'b0, x1[k]}) &&
                     ({1'b0, col} <  ({1'b0, x1[k]} + CROP_W));
        end
    end

    always_comb begin
        sel   = '0;
        tlast = 1'b0;
        for (int k = 0; k < NUM_CROPS; k++) begin
            if (sel_oh[k]) begin
                sel   = UW'(k);
                tlast = ({1'b0, row_q} == ({1'b0, y1[k]} + CROP_H_M1)) &&
                        ({1'b0, col_q} == ({1'b0, x1[k]} + CROP_W_M1));
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ap_start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cap_fire && (slot == SLOT_LAST)) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (in_fire) begin
                    if (hit != '0) begin
                        state_nxt = S_EMIT;
                    end else if (pix_last) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_EMIT: begin
                if (out_fire && mask_single) begin
                    if (in_fire) begin
                        // follow-on pixel evaluated in the same cycle
                        if (hit != '0) begin
                            state_nxt = S_EMIT;
                        end else if (pix_last) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_STREAM;
                        end
                    end else if (last_seen) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_STREAM;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= S_IDLE;
            slot      <= '0;
            row       <= '0;
            col       <= '0;
            last_seen <= 1'b0;
            pix_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            mask_q    <= '0;
            for (int k = 0; k < NUM_CROPS; k++) begin
                y1[k] <= '0;
                x1[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == S_DONE) begin
                slot      <= '0;
                row       <= '0;
                col       <= '0;
                last_seen <= 1'b0;
                mask_q    <= '0;
                for (int k = 0; k < NUM_CROPS; k++) begin
                    y1[k] <= '0;
                    x1[k] <= '0;
                end
            end else begin
                if (cap_fire) begin
                    slot <= (slot == SLOT_LAST) ? '0 : slot + UW'(1);
                end
                for (int k = 0; k < NUM_CROPS; k++) begin
                    if (cap_fire && (slot == UW'(k))) begin
                        y1[k] <= y1_clamped;
                        x1[k] <= x1_clamped;
                    end
                end

                if (in_fire) begin
                    if (pix_last) begin
                        row       <= '0;
                        col       <= '0;
                        last_seen <= 1'b1;
                    end else if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end

                if (in_fire && (hit != '0)) begin
                    pix_q  <= img_input_TDATA;
                    row_q  <= row;
                    col_q  <= col;
                    mask_q <= hit;
                end else if (out_fire) begin
                    mask_q <= mask_rem;
                end
            end
        end
    end

    assign ap_idle  = (state == S_IDLE);
    assign ap_done  = (state == S_DONE);
    assign ap_ready = (state == S_DONE);

    assign img_input_TREADY = in_rdy;
    assign crop_Y1_TREADY   = (state == S_LOAD) && crop_X1_TVALID;
    assign crop_X1_TREADY   = (state == S_LOAD) && crop_Y1_TVALID;

    assign crop_output_TVALID = out_vld;
    assign crop_output_TDATA  = pix_q;
    assign crop_output_TUSER  = sel;
    assign crop_output_TLAST  = out_vld && tlast;

endmodule

// File: tb/tb_multi_crop_stream.sv
`timescale 1ns/1ps
// Bench for multi_crop_stream: frame-level reference model (per-pixel crop hit list) fed by randomized handshakes.
// Checks every output beat, payload stability under stall, done/ready timing, reset abort and restart.
// Input TVALID and output TREADY run either always-on or 50% random.
module tb_multi_crop_stream;
    localparam int PW   = 16;
    localparam int IR   = 100;
    localparam int IC   = 160;
    localparam int OR   = 48;
    localparam int OC   = 48;
    localparam int RW   = 10;
    localparam int CW   = 10;
    localparam int NC   = 2;
    localparam int UW   = 1;
    localparam int NPIX = IR * IC;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_done, ap_ready, ap_idle;
    logic [PW-1:0] img_input_TDATA = '0;
    logic          img_input_TVALID = 1'b0;
    logic          img_input_TREADY;
    logic [RW-1:0] crop_Y1_TDATA = '0;
    logic          crop_Y1_TVALID = 1'b0;
    logic          crop_Y1_TREADY;
    logic [CW-1:0] crop_X1_TDATA = '0;
    logic          crop_X1_TVALID = 1'b0;
    logic          crop_X1_TREADY;
    logic [PW-1:0] crop_output_TDATA;
    logic          crop_output_TVALID;
    logic          crop_output_TREADY = 1'b0;
    logic [UW-1:0] crop_output_TUSER;
    logic          crop_output_TLAST;

    multi_crop_stream #(
        .PIXEL_BIT_WIDTH(PW), .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OR), .OUT_COLS(OC),
        .IMG_ROW_BITWIDTH(RW), .IMG_COL_BITWIDTH(CW), .NUM_CROPS(NC)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
        .img_input_TDATA(img_input_TDATA), .img_input_TVALID(img_input_TVALID),
        .img_input_TREADY(img_input_TREADY),
        .crop_Y1_TDATA(crop_Y1_TDATA), .crop_Y1_TVALID(crop_Y1_TVALID), .crop_Y1_TREADY(crop_Y1_TREADY),
        .crop_X1_TDATA(crop_X1_TDATA), .crop_X1_TVALID(crop_X1_TVALID), .crop_X1_TREADY(crop_X1_TREADY),
        .crop_output_TDATA(crop_output_TDATA), .crop_output_TVALID(crop_output_TVALID),
        .crop_output_TREADY(crop_output_TREADY), .crop_output_TUSER(crop_output_TUSER),
        .crop_output_TLAST(crop_output_TLAST)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int data;
        int user;
        bit last;
    } item_t;

    item_t exp_q[$];
    int    exp_low;       // input-stall cycles implied by overlapping crops at full rate
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_true(input string name, input bit cond);
        check(name, longint'(cond), 1);
    endtask

    // Expected output stream for a frame whose pixel value equals its raster index.
    function automatic void build_model(input int ya, input int xa, input int yb, input int xb);
        int cy[NC];
        int cx[NC];
        cy[0] = (ya > IR - OR) ? IR - OR : ya;
        cx[0] = (xa > IC - OC) ? IC - OC : xa;
        cy[1] = (yb > IR - OR) ? IR - OR : yb;
        cx[1] = (xb > IC - OC) ? IC - OC : xb;
        exp_q.delete();
        exp_low = 0;
        for (int p = 0; p < NPIX; p++) begin
            int r = p / IC;
            int c = p % IC;
            int m = 0;
            for (int k = 0; k < NC; k++) begin
                if (r >= cy[k] && r < cy[k] + OR && c >= cx[k] && c < cx[k] + OC) begin
                    exp_q.push_back('{data: p, user: k,
                                      last: (r == cy[k] + OR - 1) && (c == cx[k] + OC - 1)});
                    m++;
                end
            end
            if (m > 1) exp_low += m - 1;
        end
    endfunction

    // ---------------- driver ----------------
    int pix_idx   = 0;
    bit drive_en  = 1'b0;
    bit rand_mode = 1'b0;
    bit s_in_fire = 1'b0;

    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            if (s_in_fire) pix_idx++;
            img_input_TVALID   = drive_en && (pix_idx < NPIX) &&
                                 (!rand_mode || ($urandom_range(0, 1) == 1));
            img_input_TDATA    = PW'(pix_idx);
            crop_output_TREADY = !rand_mode || ($urandom_range(0, 1) == 1);
        end
    end

    // ---------------- compare process ----------------
    int done_cnt     = 0;
    int rdy_low_cnt  = 0;
    int rdy_low_1611 = 0;
    bit stall_q      = 1'b0;
    logic [PW-1:0] hold_d;
    logic [UW-1:0] hold_u;
    logic          hold_l;

    always @(negedge ap_clk) begin : mon
        item_t it;
        s_in_fire = img_input_TVALID && img_input_TREADY;
        if (!ap_rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", crop_output_TVALID, 1);
                check("stall_data", crop_output_TDATA, hold_d);
                check("stall_user", crop_output_TUSER, hold_u);
                check("stall_last", crop_output_TLAST, hold_l);
            end
            if (crop_output_TVALID && crop_output_TREADY) begin
                check_true("output_expected", exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    it = exp_q.pop_front();
                    check("out_data", crop_output_TDATA, it.data);
                    check("out_user", crop_output_TUSER, it.user);
                    check("out_last", crop_output_TLAST, it.last);
                end
            end
            stall_q = crop_output_TVALID && !crop_output_TREADY;
            hold_d  = crop_output_TDATA;
            hold_u  = crop_output_TUSER;
            hold_l  = crop_output_TLAST;
            if (ap_done) done_cnt++;
            if (drive_en && pix_idx < NPIX && !img_input_TREADY) rdy_low_cnt++;
            if (drive_en && pix_idx == 1611 && !img_input_TREADY) rdy_low_1611++;
        end
    end

    // ---------------- helpers ----------------
    task automatic check_reset_vals(input string tag);
        check({tag, "_idle"}, ap_idle, 1);
        check({tag, "_done"}, ap_done, 0);
        check({tag, "_ready"}, ap_ready, 0);
        check({tag, "_in_rdy"}, img_input_TREADY, 0);
        check({tag, "_y1_rdy"}, crop_Y1_TREADY, 0);
        check({tag, "_x1_rdy"}, crop_X1_TREADY, 0);
        check({tag, "_out_vld"}, crop_output_TVALID, 0);
        check({tag, "_out_last"}, crop_output_TLAST, 0);
        check({tag, "_out_user"}, crop_output_TUSER, 0);
        check({tag, "_out_data"}, crop_output_TDATA, 0);
    endtask

    task automatic start_load(input int ya, input int xa, input int yb, input int xb, input bit lone);
        int ys[NC];
        int xs[NC];
        int cyc;
        ys[0] = ya; xs[0] = xa; ys[1] = yb; xs[1] = xb;
        @(posedge ap_clk); #1; ap_start = 1'b1;
        @(posedge ap_clk); #1; ap_start = 1'b0;
        if (lone) begin
            // Y1 alone must sit unconsumed until X1 shows up
            crop_Y1_TDATA  = RW'(ys[0]);
            crop_Y1_TVALID = 1'b1;
            repeat (3) begin
                @(negedge ap_clk);
                check("lone_y1_rdy", crop_Y1_TREADY, 0);
                check("lone_x1_rdy", crop_X1_TREADY, 1);
            end
            @(posedge ap_clk); #1;
        end
        for (int k = 0; k < NC; k++) begin
            crop_Y1_TDATA  = RW'(ys[k]);
            crop_X1_TDATA  = CW'(xs[k]);
            crop_Y1_TVALID = 1'b1;
            crop_X1_TVALID = 1'b1;
            cyc = 0;
            do begin
                @(negedge ap_clk);
                cyc++;
            end while (!(crop_Y1_TREADY && crop_X1_TREADY) && cyc < 20);
            check_true("load_handshake", crop_Y1_TREADY && crop_X1_TREADY);
            @(posedge ap_clk); #1;
        end
        crop_Y1_TVALID = 1'b0;
        crop_X1_TVALID = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int budget);
        int cyc = 0;
        do begin
            @(negedge ap_clk);
            cyc++;
        end while (!ap_done && cyc < budget);
        check_true({tag, "_done_seen"}, ap_done);
        check({tag, "_ready_with_done"}, ap_ready, 1);
        check({tag, "_inputs_consumed"}, pix_idx, NPIX);
        check({tag, "_outputs_left"}, exp_q.size(), 0);
        @(negedge ap_clk);
        check({tag, "_idle_after"}, ap_idle, 1);
        check({tag, "_done_one_cycle"}, ap_done, 0);
        check({tag, "_no_accept_idle"}, img_input_TREADY, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        drive_en = 1'b0;
        pix_idx  = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int lasts[$];
        int users[$];
        int first_u1;

        repeat (3) @(negedge ap_clk);
        check_reset_vals("por");
        @(posedge ap_clk); #2; ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);
        check("idle_after_reset", ap_idle, 1);

        // Frame A: crops (10,10) and (80,150)->(52,112), full rate, lone Y1 and stray ap_start
        build_model(10, 10, 80, 150);
        check("model_a_count", exp_q.size(), 4608);
        check("model_a_first", exp_q[0].data, 1610);
        first_u1 = -1;
        foreach (exp_q[i]) begin
            if (exp_q[i].last) lasts.push_back(exp_q[i].data * 8 + exp_q[i].user);
            if (first_u1 < 0 && exp_q[i].user == 1) first_u1 = exp_q[i].data;
        end
        check("model_a_first_crop1", first_u1, 8432);
        check("model_a_nlast", lasts.size(), 2);
        if (lasts.size() == 2) begin
            check("model_a_last0", lasts[0], 9177 * 8 + 0);
            check("model_a_last1", lasts[1], 15999 * 8 + 1);
        end
        done_cnt = 0; rdy_low_cnt = 0; rdy_low_1611 = 0; rand_mode = 1'b0;
        start_load(10, 10, 80, 150, 1'b1);
        drive_en = 1'b1;
        repeat (200) @(posedge ap_clk);
        #1; ap_start = 1'b1;
        @(posedge ap_clk); #1; ap_start = 1'b0;
        finish_frame("a", 25000);
        check("a_in_stall_cycles", rdy_low_cnt, exp_low);

        // Frame B: reset after 5000 inputs, then restart under 50% random handshakes
        build_model(10, 10, 80, 150);
        done_cnt = 0;
        start_load(10, 10, 80, 150, 1'b0);
        drive_en = 1'b1;
        cyc = 0;
        while (pix_idx < 5000 && cyc < 20000) begin
            @(negedge ap_clk);
            cyc++;
        end
        check_true("abort_reached_5000", pix_idx >= 5000);
        @(posedge ap_clk); #2; ap_rst_n = 1'b0; drive_en = 1'b0;
        @(negedge ap_clk);
        check_reset_vals("abort");
        exp_q.delete();
        pix_idx = 0;
        repeat (2) @(negedge ap_clk);
        check_reset_vals("abort_hold");
        check("abort_no_done", done_cnt, 0);
        @(posedge ap_clk); #2; ap_rst_n = 1'b1;

        build_model(10, 10, 80, 150);
        done_cnt = 0; rand_mode = 1'b1;
        start_load(10, 10, 80, 150, 1'b0);
        drive_en = 1'b1;
        finish_frame("b", 60000);
        rand_mode = 1'b0;

        // Frame C: overlapping crops (0,0) and (10,10)
        build_model(0, 0, 10, 10);
        check("model_c_count", exp_q.size(), 4608);
        foreach (exp_q[i]) if (exp_q[i].data == 1610) users.push_back(exp_q[i].user);
        check("model_c_1610_copies", users.size(), 2);
        if (users.size() == 2) begin
            check("model_c_1610_user0", users[0], 0);
            check("model_c_1610_user1", users[1], 1);
        end
        done_cnt = 0; rdy_low_cnt = 0; rdy_low_1611 = 0;
        start_load(0, 0, 10, 10, 1'b0);
        drive_en = 1'b1;
        finish_frame("c", 25000);
        check("c_stall_at_1610", rdy_low_1611, 1);
        check("c_in_stall_cycles", rdy_low_cnt, exp_low);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
